// File: rtl/text_scan_ctrl_if.sv
// Video-RAM port and CPU character-write handshake shared by the text scan controller.
// master = controller side, slave = RAM/CPU side.
interface text_scan_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_rd;
  logic              vram_we;
  logic [5:0]        vram_wdata;
  logic [5:0]        vram_rdata;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [5:0]        cpu_data;
  logic              cpu_ack;

  modport master (
    output vram_addr, vram_rd, vram_we, vram_wdata, cpu_ack,
    input  vram_rdata, cpu_req, cpu_addr, cpu_data
  );

  modport slave (
    input  vram_addr, vram_rd, vram_we, vram_wdata, cpu_ack,
    output vram_rdata, cpu_req, cpu_addr, cpu_data
  );
endinterface

// File: rtl/text_scan_ctrl.sv
// Text-mode scan sequencer: walks the character grid, prefetches cell codes one cell ahead,
// arbitrates the video-RAM port (display first, CPU second) and overlays the cursor.
// Optional macro TEXT_CURSOR_BLINK_EN: cursor blinks every BLINK_FRAMES frame_sync pulses.
module text_scan_ctrl #(
  parameter int         COLS         = 40,
  parameter int         ROWS         = 24,
  parameter int         CHAR_W       = 16,
  parameter int         CHAR_H       = 20,
  parameter int         ADDR_W       = 10,
  parameter logic [5:0] CURSOR_CHAR  = 6'h00,
  parameter int         BLINK_FRAMES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pix_en,
  input  logic                      active,
  input  logic                      frame_sync,
  input  logic [ADDR_W-1:0]         cursor_addr,
  text_scan_ctrl_if.master          bus,
  output logic [5:0]                font_character,
  output logic [$clog2(CHAR_W)-1:0] font_pixel,
  output logic [$clog2(CHAR_H)-1:0] font_line,
  output logic                      pix_valid
);

  localparam int PIX_W  = $clog2(CHAR_W);
  localparam int COL_W  = $clog2(COLS);
  localparam int LINE_W = $clog2(CHAR_H);
  localparam int ROW_W  = $clog2(ROWS);
  localparam logic [ADDR_W:0] CELLS = (ADDR_W+1)'(COLS * ROWS);

  // scan counters
  logic [PIX_W-1:0]  pix_reg, pix_next;
  logic [COL_W-1:0]  col_reg, col_next;
  logic [LINE_W-1:0] line_reg, line_next;
  logic [ROW_W-1:0]  row_reg, row_next;
  logic [ADDR_W-1:0] row_base_reg, row_base_next;

  // fetch pipeline
  logic [5:0]        cur_char_reg, cur_char_next;
  logic [5:0]        next_char_reg, next_char_next;
  logic              fetch_pend_reg, fetch_pend_next;
  logic [ADDR_W-1:0] fetch_addr_reg, fetch_addr_next;
  logic              rd_dly_reg, rd_dly_next;

  // RAM port
  logic [ADDR_W-1:0] vram_addr_reg, vram_addr_next;
  logic              vram_rd_reg, vram_rd_next;
  logic              vram_we_reg, vram_we_next;
  logic [5:0]        vram_wdata_reg, vram_wdata_next;
  logic              cpu_ack_reg, cpu_ack_next;

  // font ROM side
  logic [5:0]        font_character_reg, font_character_next;
  logic [PIX_W-1:0]  font_pixel_reg, font_pixel_next;
  logic [LINE_W-1:0] font_line_reg, font_line_next;
  logic              pix_valid_reg, pix_valid_next;

  logic              blink_on;
  logic              advance;
  logic              pix_last, col_last, line_last, row_last;
  logic [ADDR_W-1:0] cell_idx;
  logic              fetch_grant, cpu_grant, cpu_addr_ok;

  assign advance   = pix_en & active & ~frame_sync;
  assign pix_last  = (pix_reg  == PIX_W'(CHAR_W - 1));
  assign col_last  = (col_reg  == COL_W'(COLS - 1));
  assign line_last = (line_reg == LINE_W'(CHAR_H - 1));
  assign row_last  = (row_reg  == ROW_W'(ROWS - 1));
  assign cell_idx  = row_base_reg + ADDR_W'(col_reg);

  // A pending display fetch always wins; the CPU is not re-granted during its own ack cycle.
  assign fetch_grant = fetch_pend_reg;
  assign cpu_grant   = ~fetch_pend_reg & bus.cpu_req & ~cpu_ack_reg;
  assign cpu_addr_ok = ({1'b0, bus.cpu_addr} < CELLS);

  always_comb begin
    vram_rd_next    = 1'b0;
    vram_we_next    = 1'b0;
    vram_addr_next  = vram_addr_reg;
    vram_wdata_next = vram_wdata_reg;
    cpu_ack_next    = 1'b0;
    rd_dly_next     = vram_rd_reg;
    next_char_next  = next_char_reg;

    if (rd_dly_reg) begin
      next_char_next = bus.vram_rdata;
    end

    if (fetch_grant) begin
      vram_rd_next   = 1'b1;
      vram_addr_next = fetch_addr_reg;
    end else if (cpu_grant) begin
      cpu_ack_next = 1'b1;
      if (cpu_addr_ok) begin
        vram_we_next    = 1'b1;
        vram_addr_next  = bus.cpu_addr;
        vram_wdata_next = bus.cpu_data;
      end
    end
  end

  always_comb begin
    pix_next        = pix_reg;
    col_next        = col_reg;
    line_next       = line_reg;
    row_next        = row_reg;
    row_base_next   = row_base_reg;
    cur_char_next   = cur_char_reg;
    fetch_pend_next = fetch_pend_reg & ~fetch_grant;
    fetch_addr_next = fetch_addr_reg;

    if (frame_sync) begin
      pix_next        = '0;
      col_next        = '0;
      line_next       = '0;
      row_next        = '0;
      row_base_next   = '0;
      fetch_pend_next = 1'b1;
      fetch_addr_next = '0;
    end else if (advance) begin
      if (!pix_last) begin
        pix_next = pix_reg + PIX_W'(1);
      end else begin
        // cell boundary: promote the prefetched code and queue the following cell
        pix_next        = '0;
        cur_char_next   = next_char_reg;
        fetch_pend_next = 1'b1;
        if (!col_last) begin
          col_next        = col_reg + COL_W'(1);
          fetch_addr_next = cell_idx + ADDR_W'(1);
        end else begin
          col_next = '0;
          if (!line_last) begin
            line_next       = line_reg + LINE_W'(1);
            fetch_addr_next = row_base_reg;
          end else begin
            line_next = '0;
            if (!row_last) begin
              row_next        = row_reg + ROW_W'(1);
              row_base_next   = row_base_reg + ADDR_W'(COLS);
              fetch_addr_next = row_base_reg + ADDR_W'(COLS);
            end else begin
              row_next        = '0;
              row_base_next   = '0;
              fetch_addr_next = '0;
            end
          end
        end
      end
    end
  end

  always_comb begin
    font_character_next = cur_char_reg;
    if (blink_on && (cell_idx == cursor_addr)) begin
      font_character_next = CURSOR_CHAR;
    end
    font_pixel_next = pix_reg;
    font_line_next  = line_reg;
    pix_valid_next  = pix_en & active;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_reg            <= '0;
      col_reg            <= '0;
      line_reg           <= '0;
      row_reg            <= '0;
      row_base_reg       <= '0;
      cur_char_reg       <= '0;
      next_char_reg      <= '0;
      fetch_pend_reg     <= 1'b1;
      fetch_addr_reg     <= '0;
      rd_dly_reg         <= 1'b0;
      vram_addr_reg      <= '0;
      vram_rd_reg        <= 1'b0;
      vram_we_reg        <= 1'b0;
      vram_wdata_reg     <= '0;
      cpu_ack_reg        <= 1'b0;
      font_character_reg <= '0;
      font_pixel_reg     <= '0;
      font_line_reg      <= '0;
      pix_valid_reg      <= 1'b0;
    end else begin
      pix_reg            <= pix_next;
      col_reg            <= col_next;
      line_reg           <= line_next;
      row_reg            <= row_next;
      row_base_reg       <= row_base_next;
      cur_char_reg       <= cur_char_next;
      next_char_reg      <= next_char_next;
      fetch_pend_reg     <= fetch_pend_next;
      fetch_addr_reg     <= fetch_addr_next;
      rd_dly_reg         <= rd_dly_next;
      vram_addr_reg      <= vram_addr_next;
      vram_rd_reg        <= vram_rd_next;
      vram_we_reg        <= vram_we_next;
      vram_wdata_reg     <= vram_wdata_next;
      cpu_ack_reg        <= cpu_ack_next;
      font_character_reg <= font_character_next;
      font_pixel_reg     <= font_pixel_next;
      font_line_reg      <= font_line_next;
      pix_valid_reg      <= pix_valid_next;
    end
  end

`ifdef TEXT_CURSOR_BLINK_EN
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FRAME_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic               blink_on_reg, blink_on_next;

  always_comb begin
    frame_cnt_next = frame_cnt_reg;
    blink_on_next  = blink_on_reg;
    if (frame_sync) begin
      if (frame_cnt_reg == FRAME_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_next = '0;
        blink_on_next  = ~blink_on_reg;
      end else begin
        frame_cnt_next = frame_cnt_reg + FRAME_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
    end else begin
      frame_cnt_reg <= frame_cnt_next;
      blink_on_reg  <= blink_on_next;
    end
  end

  assign blink_on = blink_on_reg;
`else
  // steady cursor; any legal (non-zero) period leaves it permanently on
  assign blink_on = (BLINK_FRAMES > 0);
`endif

  assign bus.vram_addr  = vram_addr_reg;
  assign bus.vram_rd    = vram_rd_reg;
  assign bus.vram_we    = vram_we_reg;
  assign bus.vram_wdata = vram_wdata_reg;
  assign bus.cpu_ack    = cpu_ack_reg;
  assign font_character = font_character_reg;
  assign font_pixel     = font_pixel_reg;
  assign font_line      = font_line_reg;
  assign pix_valid      = pix_valid_reg;

endmodule

// File: tb/tb_text_scan_ctrl.sv
// Directed bench for text_scan_ctrl: scan/fetch order, CPU arbitration, cursor/blink, reset.
module tb_text_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_en, active, frame_sync;
  logic [9:0] cursor_addr;
  logic [5:0] font_character;
  logic [3:0] font_pixel;
  logic [4:0] font_line;
  logic       pix_valid;

  int n_cmp  = 0;
  int n_fail = 0;
  int ack_cnt = 0;
  int we_cnt  = 0;
  int snap;

  logic [5:0] mem [0:1023];
  logic [9:0] last_rd_addr;

`ifdef TEXT_CURSOR_BLINK_EN
  localparam logic [5:0] BLINK_OFF_EXP = 6'h22;
`else
  localparam logic [5:0] BLINK_OFF_EXP = 6'h00;
`endif

  text_scan_ctrl_if #(.ADDR_W(10)) bus ();

  text_scan_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .pix_en         (pix_en),
    .active         (active),
    .frame_sync     (frame_sync),
    .cursor_addr    (cursor_addr),
    .bus            (bus),
    .font_character (font_character),
    .font_pixel     (font_pixel),
    .font_line      (font_line),
    .pix_valid      (pix_valid)
  );

  always #5 clk = ~clk;

  // cells 40 and 41 share a code so the cursor cell shows it either way
  function automatic logic [5:0] init_val(input int i);
    if (i == 40 || i == 41) return 6'h22;
    return 6'(i * 7 + 3);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      bus.vram_rdata <= '0;
      last_rd_addr   <= '0;
    end else begin
      if (bus.vram_we) mem[bus.vram_addr] <= bus.vram_wdata;
      if (bus.vram_rd) begin
        bus.vram_rdata <= mem[bus.vram_addr];
        last_rd_addr   <= bus.vram_addr;
      end
    end
    if (bus.cpu_ack) ack_cnt <= ack_cnt + 1;
    if (bus.vram_we) we_cnt  <= we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-18s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_pix(input int n);
    for (int i = 0; i < n; i++) begin
      pix_en = 1'b1;
      active = 1'b1;
      @(negedge clk);
    end
    pix_en = 1'b0;
    active = 1'b0;
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; pix_en = 1'b0; active = 1'b0; frame_sync = 1'b0;
    cursor_addr = 10'd41;
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
    idle(3);
    chk("rst_vram_rd", 32'(bus.vram_rd), 32'd0);
    chk("rst_vram_we", 32'(bus.vram_we), 32'd0);
    chk("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    chk("rst_vram_addr", 32'(bus.vram_addr), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_font_char", 32'(font_character), 32'd0);
    reset = 1'b0;
    idle(4);

    // frame_sync: fetch of cell 0 issued on the following cycle
    pulse_sync();
    @(negedge clk);
    chk("sync_fetch_rd", 32'(bus.vram_rd), 32'd1);
    chk("sync_fetch_addr", 32'(bus.vram_addr), 32'd0);
    idle(3);

    run_pix(1);
    chk("pix0_valid", 32'(pix_valid), 32'd1);
    chk("pix0_font_pixel", 32'(font_pixel), 32'd0);
    run_pix(15);
    idle(4);
    chk("cell0_char", 32'(font_character), 32'd3);
    chk("cell0_next_fetch", 32'(last_rd_addr), 32'd1);
    chk("idle_pix_valid", 32'(pix_valid), 32'd0);

    run_pix(624);
    idle(4);
    chk("line0_end_fetch", 32'(last_rd_addr), 32'd0);
    run_pix(1);
    chk("line1_font_line", 32'(font_line), 32'd1);
    chk("line1_font_pixel", 32'(font_pixel), 32'd0);
    run_pix(12159);
    idle(4);
    chk("row0_end_fetch", 32'(last_rd_addr), 32'd40);

    // row 1 col 1 is the cursor cell (41); blink phase on in frame 1
    run_pix(16);
    idle(2);
    chk("cursor_f1", 32'(font_character), 32'h00);

    repeat (14) begin
      pulse_sync();
      @(negedge clk);
    end
    idle(4);
    run_pix(12816);
    idle(2);
    chk("cursor_f15", 32'(font_character), 32'h00);

    pulse_sync();
    idle(4);
    run_pix(12816);
    idle(2);
    chk("cursor_f16", 32'(font_character), 32'(BLINK_OFF_EXP));

    // CPU write held during a display fetch: fetch first, then the write
    pulse_sync();
    bus.cpu_req = 1'b1; bus.cpu_addr = 10'd5; bus.cpu_data = 6'h2A;
    snap = ack_cnt;
    @(negedge clk);
    chk("arb_fetch_rd", 32'(bus.vram_rd), 32'd1);
    chk("arb_fetch_we", 32'(bus.vram_we), 32'd0);
    chk("arb_fetch_ack", 32'(bus.cpu_ack), 32'd0);
    @(negedge clk);
    chk("arb_cpu_we", 32'(bus.vram_we), 32'd1);
    chk("arb_cpu_addr", 32'(bus.vram_addr), 32'd5);
    chk("arb_cpu_wdata", 32'(bus.vram_wdata), 32'h2A);
    chk("arb_cpu_ack", 32'(bus.cpu_ack), 32'd1);
    chk("arb_cpu_rd", 32'(bus.vram_rd), 32'd0);
    bus.cpu_req = 1'b0;
    idle(4);
    chk("arb_ack_count", 32'(ack_cnt - snap), 32'd1);
    chk("arb_mem5", 32'(mem[5]), 32'h2A);

    // out-of-range write: acked, never written
    bus.cpu_req = 1'b1; bus.cpu_addr = 10'd960; bus.cpu_data = 6'h15;
    snap = we_cnt;
    @(negedge clk);
    chk("oob_ack", 32'(bus.cpu_ack), 32'd1);
    chk("oob_we", 32'(bus.vram_we), 32'd0);
    bus.cpu_req = 1'b0;
    idle(3);
    chk("oob_we_count", 32'(we_cnt - snap), 32'd0);

    // request still high after the ack cycle counts as a second request
    bus.cpu_req = 1'b1; bus.cpu_addr = 10'd7; bus.cpu_data = 6'h11;
    snap = ack_cnt;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rereq_ack", 32'(bus.cpu_ack), 32'd1);
    bus.cpu_req = 1'b0;
    idle(3);
    chk("rereq_ack_count", 32'(ack_cnt - snap), 32'd2);

    // reset in the middle of row 0: cell 6 displays cell 5 (now 0x2A)
    pulse_sync();
    idle(4);
    for (int i = 0; i < 100; i++) begin
      pix_en = 1'b1;
      active = 1'b1;
      @(negedge clk);
    end
    chk("pre_rst_pixel", 32'(font_pixel), 32'd3);
    chk("pre_rst_addr", 32'(bus.vram_addr), 32'd6);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(pix_valid), 32'd0);
    chk("mid_rst_pixel", 32'(font_pixel), 32'd0);
    chk("mid_rst_addr", 32'(bus.vram_addr), 32'd0);
    chk("mid_rst_char", 32'(font_character), 32'd0);
    pix_en = 1'b0;
    active = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rd", 32'(bus.vram_rd), 32'd1);
    chk("post_rst_addr", 32'(bus.vram_addr), 32'd0);
    idle(3);
    run_pix(16);
    idle(4);
    chk("post_rst_fetch", 32'(last_rd_addr), 32'd1);
    chk("post_rst_char", 32'(font_character), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
